// File: rtl/modred_mont_iter.sv
// Iterative word-serial Montgomery reduction: R = T * 2^-LOGQ mod q.
// W bits of T are retired per iteration; one reduction in flight, valid/ready on both sides.
module modred_mont_iter #(
  parameter int LOGQ    = 60,
  parameter int W       = 20,
  parameter int FF_ITER = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LOGQ-1:0]   q,
  input  logic [W-1:0]      q_inv_neg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] T,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   R,
  output logic              busy
);
  localparam int N  = LOGQ / W;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2*LOGQ + 1;
  localparam int PW = LOGQ + W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   acc_r;
  logic [LOGQ-1:0] q_r;
  logic [W-1:0]    qinv_r;
  logic [W-1:0]    m_r;
  logic            phase_r;
  logic [CW-1:0]   cnt_r;

  logic [W-1:0]    m_now_s;
  logic [W-1:0]    m_use_s;
  logic [PW-1:0]   m_ext_s;
  logic [PW-1:0]   q_ext_s;
  logic [PW-1:0]   mq_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   acc_next_s;
  logic [LOGQ-1:0] diff_s;
  logic            ge_q_s;
  logic            step_s;
  logic            last_s;

  // Digit m, the m*q accumulate and the final conditional subtract
  always_comb begin
    m_now_s    = acc_r[W-1:0] * qinv_r;
    m_use_s    = (FF_ITER != 0) ? m_r : m_now_s;
    m_ext_s    = {{LOGQ{1'b0}}, m_use_s};
    q_ext_s    = {{W{1'b0}}, q_r};
    mq_s       = m_ext_s * q_ext_s;
    // low W bits of the sum are zero by choice of m, so the shift is exact
    sum_s      = acc_r + {{(AW-PW){1'b0}}, mq_s};
    acc_next_s = sum_s >> W;
    ge_q_s     = (acc_r >= {{(AW-LOGQ){1'b0}}, q_r});
    diff_s     = acc_r[LOGQ-1:0] - q_r;
    step_s     = (FF_ITER == 0) || phase_r;
    last_s     = (cnt_r == CW'(N-1));
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      R         <= {LOGQ{1'b0}};
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {AW{1'b0}};
      q_r       <= {LOGQ{1'b0}};
      qinv_r    <= {W{1'b0}};
      m_r       <= {W{1'b0}};
      phase_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc_r    <= {1'b0, T};
            q_r      <= q;
            qinv_r   <= q_inv_neg;
            cnt_r    <= {CW{1'b0}};
            phase_r  <= 1'b0;
            state_r  <= ITER;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state_r  <= IDLE;
          end
        end
        ITER: begin
          if (step_s) begin
            acc_r   <= acc_next_s;
            cnt_r   <= cnt_r + CW'(1);
            phase_r <= 1'b0;
            if (last_s) begin
              state_r <= FINAL;
            end else begin
              state_r <= ITER;
            end
          end else begin
            // first half of a split iteration: hold the digit for the accumulate
            m_r     <= m_now_s;
            phase_r <= 1'b1;
          end
        end
        FINAL: begin
          R         <= ge_q_s ? diff_s : acc_r[LOGQ-1:0];
          state_r   <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modred_mont_iter.sv
// Randomized bench for modred_mont_iter (FF_ITER=0 and FF_ITER=1 instances) against a
// cycle-level behavioural model using plain modular arithmetic.
module tb_modred_mont_iter;
  localparam logic [59:0] Q0 = 60'hFFFFFFFFFFFFFA3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [59:0]  q = 60'd0;
  logic [19:0]  q_inv_neg = 20'd0;
  logic [119:0] T = 120'd0;
  logic         out_ready = 1'b1;
  logic         in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic         in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [59:0]  R0, R1;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  modred_mont_iter #(.LOGQ(60), .W(20), .FF_ITER(0)) u0 (
    .clk(clk), .rst(rst), .q(q), .q_inv_neg(q_inv_neg), .in_valid(in_valid0),
    .in_ready(in_ready0), .T(T), .out_valid(out_valid0), .out_ready(out_ready),
    .R(R0), .busy(busy0));

  modred_mont_iter #(.LOGQ(60), .W(20), .FF_ITER(1)) u1 (
    .clk(clk), .rst(rst), .q(q), .q_inv_neg(q_inv_neg), .in_valid(in_valid1),
    .in_ready(in_ready1), .T(T), .out_valid(out_valid1), .out_ready(out_ready),
    .R(R1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // T * 2^-60 mod q: reduce, then halve modulo q sixty times
  function automatic logic [59:0] mont_ref(input logic [119:0] t, input logic [59:0] qq);
    logic [119:0] r;
    logic [60:0]  x;
    r = t % {60'd0, qq};
    x = {1'b0, r[59:0]};
    for (int i = 0; i < 60; i++) begin
      if (x[0]) x = x + {1'b0, qq};
      x = x >> 1;
    end
    return x[59:0];
  endfunction

  // (-q^-1) mod 2^20 by Newton iteration in 64-bit arithmetic
  function automatic logic [19:0] qinv_of(input logic [59:0] qq);
    logic [63:0] x, qe, nx;
    qe = {4'd0, qq};
    x  = qe;
    for (int i = 0; i < 5; i++) x = x * (64'd2 - qe * x);
    nx = 64'd0 - x;
    return nx[19:0];
  endfunction

  function automatic logic [59:0] rand60();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[59:0];
  endfunction

  function automatic logic [119:0] rand_t(input logic [59:0] qq);
    logic [59:0] hi;
    hi = rand60() % qq;
    return {hi, rand60()};
  endfunction

  function automatic bit rdy(input int k);
    return (k == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic bit ov(input int k);
    return (k == 0) ? out_valid0 : out_valid1;
  endfunction

  function automatic logic [59:0] rr(input int k);
    return (k == 0) ? R0 : R1;
  endfunction

  task automatic set_iv(input int k, input bit v);
    if (k == 0) in_valid0 = v; else in_valid1 = v;
  endtask

  // Behavioural model: expected outputs for the next cycle
  bit          m_ready[2] = '{1'b1, 1'b1};
  bit          m_valid[2] = '{1'b0, 1'b0};
  bit          m_pend[2]  = '{1'b0, 1'b0};
  logic [59:0] m_R[2]     = '{60'd0, 60'd0};
  logic [59:0] m_exp[2]   = '{60'd0, 60'd0};
  int          m_due[2]   = '{0, 0};
  int          lat[2]     = '{5, 8};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit iv;
      iv = (k == 0) ? in_valid0 : in_valid1;
      if (chk_en) begin
        chk($sformatf("in_ready%0d", k), {127'd0, rdy(k)}, {127'd0, m_ready[k]});
        chk($sformatf("out_valid%0d", k), {127'd0, ov(k)}, {127'd0, m_valid[k]});
        chk($sformatf("busy%0d", k), {127'd0, (k == 0) ? busy0 : busy1}, {127'd0, !m_ready[k]});
        chk($sformatf("R%0d", k), {68'd0, rr(k)}, {68'd0, m_R[k]});
      end
      if (rst) begin
        m_ready[k] = 1'b1; m_valid[k] = 1'b0; m_R[k] = 60'd0; m_pend[k] = 1'b0;
      end else if (m_ready[k] && iv) begin
        m_ready[k] = 1'b0; m_pend[k] = 1'b1;
        m_exp[k] = mont_ref(T, q);
        m_due[k] = cyc + lat[k];
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 1'b0; m_ready[k] = 1'b1;
      end else if (m_pend[k] && (cyc + 1 == m_due[k])) begin
        m_valid[k] = 1'b1; m_R[k] = m_exp[k]; m_pend[k] = 1'b0;
      end
    end
  end

  // Present T until accepted; returns the handshake cycle
  task automatic send(input int k, input logic [119:0] t, input logic [59:0] qq, output int acc_cyc);
    int n;
    bit hs;
    n = 0; hs = 1'b0; acc_cyc = -1;
    T = t; q = qq; q_inv_neg = qinv_of(qq);
    set_iv(k, 1'b1);
    while (!hs && n < 50) begin
      @(negedge clk);
      if (rdy(k)) begin hs = 1'b1; acc_cyc = cyc; end
      @(posedge clk); #1;
      n++;
    end
    set_iv(k, 1'b0);
    T = {rand60(), rand60()};
    q = rand60();
    if (!hs) chk("send_timeout", 128'd0, 128'd1);
  endtask

  // Wait for the result, stalling 'stall' cycles in DONE; optionally poke in_valid meanwhile
  task automatic recv(input int k, input int stall, input bit poke, output logic [59:0] res, output int out_cyc);
    int n, s;
    bit hs;
    n = 0; s = stall; hs = 1'b0; res = 60'd0; out_cyc = -1;
    while (!hs && n < 100) begin
      out_ready = (s == 0);
      set_iv(k, poke && (s > 0) && ov(k));
      @(negedge clk);
      if (ov(k)) begin
        if (out_ready) begin hs = 1'b1; res = rr(k); out_cyc = cyc; end
        else s--;
      end
      @(posedge clk); #1;
      n++;
    end
    set_iv(k, 1'b0);
    out_ready = 1'b1;
    if (!hs) chk("recv_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail + 1);
    $fatal(1);
  end

  initial begin
    int a, o, n, acc_n, out_n;
    logic [59:0] res, qr;
    logic [119:0] tq[3];
    int outc[3];
    logic [79:0] pp;

    // model pins
    chk("ref_zero", {68'd0, mont_ref(120'd0, Q0)}, 128'd0);
    chk("ref_5", {68'd0, mont_ref({60'd5, 60'd0}, Q0)}, 128'd5);
    chk("ref_qm1", {68'd0, mont_ref({Q0 - 60'd1, 60'd0}, Q0)}, {68'd0, Q0 - 60'd1});
    chk("ref_q7", {68'd0, mont_ref(120'd13, 60'd7)}, 128'd6);
    pp = {20'd0, qinv_of(Q0)} * {20'd0, Q0};
    chk("qinv_pin", {108'd0, pp[19:0]}, {108'd0, 20'hFFFFF});

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T=0: out_valid 5 cycles after the input handshake
    send(0, 120'd0, Q0, a);
    recv(0, 0, 1'b0, res, o);
    chk("t0_R", {68'd0, res}, 128'd0);
    chk("t0_latency", o - a, 128'd5);

    // directed values
    send(0, {60'd5, 60'd0}, Q0, a);
    recv(0, 0, 1'b0, res, o);
    chk("t5_R", {68'd0, res}, 128'd5);
    send(0, {Q0 - 60'd1, 60'd0}, Q0, a);
    recv(0, 0, 1'b0, res, o);
    chk("tqm1_R", {68'd0, res}, {68'd0, Q0 - 60'd1});
    send(0, {Q0, 60'd0} - 120'd1, Q0, a);
    recv(0, 0, 1'b0, res, o);
    chk("tmax_R", {68'd0, res}, {68'd0, mont_ref({Q0, 60'd0} - 120'd1, Q0)});
    send(1, {Q0, 60'd0} - 120'd1, Q0, a);
    recv(1, 0, 1'b0, res, o);
    chk("tmax_R_ff", {68'd0, res}, {68'd0, mont_ref({Q0, 60'd0} - 120'd1, Q0)});
    chk("ff_latency", o - a, 128'd8);

    // backpressure with an ignored in_valid pulse
    send(0, rand_t(Q0), Q0, a);
    recv(0, 7, 1'b1, res, o);
    chk("bp_latency", o - a, 128'd12);

    // reset mid-ITER: handshake in cycle 0, rst in cycle 2
    send(0, rand_t(Q0), Q0, a);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid0}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready0}, 128'd1);
    chk("rst_R", {68'd0, R0}, 128'd0);
    @(posedge clk); #1;
    send(0, {60'd5, 60'd0}, Q0, a);
    recv(0, 0, 1'b0, res, o);
    chk("post_rst_R", {68'd0, res}, 128'd5);

    // back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) tq[i] = rand_t(Q0);
    acc_n = 0; out_n = 0; n = 0;
    T = tq[0]; q = Q0; q_inv_neg = qinv_of(Q0); in_valid0 = 1'b1; out_ready = 1'b1;
    while (out_n < 3 && n < 100) begin
      @(negedge clk);
      if (in_valid0 && in_ready0) acc_n++;
      if (out_valid0 && out_ready) begin
        outc[out_n] = cyc;
        chk("b2b_R", {68'd0, R0}, {68'd0, mont_ref(tq[out_n], Q0)});
        out_n++;
      end
      @(posedge clk); #1;
      n++;
      if (acc_n < 3) T = tq[acc_n]; else in_valid0 = 1'b0;
    end
    in_valid0 = 1'b0;
    chk("b2b_count", out_n, 128'd3);
    if (out_n == 3) begin
      chk("b2b_gap1", outc[1] - outc[0], 128'd6);
      chk("b2b_gap2", outc[2] - outc[1], 128'd6);
    end

    // randomized: random odd 60-bit q, legal T, random stalls, both FF_ITER settings
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [119:0] tr;
        qr = rand60() | 60'h800000000000001;
        tr = rand_t(qr);
        send(k, tr, qr, a);
        recv(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0, res, o);
        chk("rand_R", {68'd0, res}, {68'd0, mont_ref(tr, qr)});
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
